// File: rtl/data_memory_responder.sv
// Wait-stated data memory responder: one access at a time, IDLE -> WAIT -> RESP handshake.
// Define DMEM_BYTE_MASK_EN to add the req_bytemask port for byte-granular stores.
module data_memory_responder #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_MASK_EN
  input  logic [3:0]  req_bytemask,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        load_ok_q, load_ok_d;
  logic        enter_resp;
`ifdef DMEM_BYTE_MASK_EN
  logic [3:0]  mask_q, mask_d;
`endif

  logic [31:0] mem [DEPTH];
  logic [31:0] mem_rdata_q;

  // Access fields: with zero wait states the storage is touched on the acceptance
  // edge itself, so the live request is used while still in IDLE.
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_mask;
  logic [31:0]           acc_offset;
  logic [31:0]           acc_word;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_err;
  logic                  mem_we;
  logic                  mem_re;
  logic [3:0]            byte_we;

  assign acc_write  = (state_q == S_IDLE) ? req_write : write_q;
  assign acc_addr   = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign acc_wdata  = (state_q == S_IDLE) ? req_wdata : wdata_q;
`ifdef DMEM_BYTE_MASK_EN
  assign acc_mask   = (state_q == S_IDLE) ? req_bytemask : mask_q;
`else
  assign acc_mask   = 4'hF;
`endif

  // Offset wraps modulo 2**32, so addresses below the base land far out of range.
  assign acc_offset = acc_addr - BASE_ADDR;
  assign acc_word   = acc_offset >> 2;
  assign acc_idx    = acc_word[DEPTH_LOG2-1:0];
  assign acc_err    = (acc_addr[1:0] != 2'b00) || ((acc_word >> DEPTH_LOG2) != 32'd0);

  assign mem_we = enter_resp && !reset && acc_write && !acc_err;
  assign mem_re = enter_resp && !reset && !acc_write && !acc_err;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_we
      assign byte_we[gi] = mem_we && acc_mask[gi];
    end
  endgenerate

  // Storage is deliberately never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_we[b]) begin
        mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
    if (mem_re) begin
      mem_rdata_q <= mem[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
`ifdef DMEM_BYTE_MASK_EN
      mask_q    <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      load_ok_q <= load_ok_d;
`ifdef DMEM_BYTE_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    load_ok_d  = load_ok_q;
    enter_resp = 1'b0;
`ifdef DMEM_BYTE_MASK_EN
    mask_d     = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef DMEM_BYTE_MASK_EN
          mask_d  = req_bytemask;
`endif
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Response status is latched on the same edge that touches the storage.
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      enter_resp = 1'b1;
      err_d      = acc_err;
      load_ok_d  = !acc_write && !acc_err;
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_error = (state_q == S_RESP) && err_q;
    resp_rdata = ((state_q == S_RESP) && load_ok_q) ? mem_rdata_q : 32'd0;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, SHALL set the word count of the internal storage to 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h10010000, SHALL set the byte address of word 0.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15, SHALL set the number of wait-state cycles inserted per access.
REQ-004 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: req_valid  input  1  processor presents an access.
REQ-007 Port: req_ready  output  1  responder accepts an access this cycle.
REQ-008 Port: req_write  input  1  1 = store, 0 = load.
REQ-009 Port: req_addr  input  32  byte address (processor ALU result).
REQ-010 Port: req_wdata  input  32  store data.
REQ-011 Port: resp_valid  output  1  response available.
REQ-012 Port: resp_ready  input  1  processor consumes the response.
REQ-013 Port: resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 Port: resp_error  output  1  access was misaligned or out of range.

Function
REQ-015 States SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-016 An access SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_write, req_addr, req_wdata SHALL be registered at that edge and ignored afterwards.
REQ-017 On acceptance: WAIT_CYCLES>0 -> WAIT with counter loaded to WAIT_CYCLES-1; WAIT_CYCLES=0 -> RESP directly.
REQ-018 In WAIT the counter SHALL decrement each cycle; transition to RESP on the edge where counter=0.
REQ-019 The storage access SHALL occur on the edge entering RESP: load data captured into resp_rdata, store data written; resp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after acceptance.
REQ-020 Word index SHALL be (req_addr-BASE_ADDR)>>2 computed modulo 2**32; access is in range iff index < 2**DEPTH_LOG2.
REQ-021 req_addr[1:0]!=0 or out-of-range SHALL set resp_error=1, resp_rdata=0, and SHALL NOT modify storage.
REQ-022 resp_valid, resp_rdata, resp_error SHALL be held stable in RESP until resp_ready=1; on that edge the state SHALL return to IDLE.
REQ-023 Back-to-back: a new access SHALL NOT be accepted in the cycle a response is consumed; earliest acceptance is the following cycle (IDLE).
REQ-024 A load following a store to the same word SHALL return the stored value.
REQ-025 Storage contents SHALL be unspecified after power-up; word values SHALL NOT be cleared by reset.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_error=0, req_ready=1 from the next cycle.
REQ-027 reset asserted in WAIT SHALL abort the access with no storage write; reset asserted in RESP SHALL discard the pending response.
REQ-028 reset SHALL take priority over acceptance and resp_ready on the same edge.

Configuration
REQ-029 Macro DMEM_BYTE_MASK_EN defined: port req_bytemask input 4 SHALL exist, registered at acceptance; a store writes only bytes whose mask bit is 1 (bit0 = bits 7:0); loads ignore the mask; mask 4'b0000 store is a legal no-op.
REQ-030 Macro DMEM_BYTE_MASK_EN undefined: port req_bytemask SHALL NOT exist and every store SHALL write all 32 bits.

Verification
REQ-031 Reset, then store 32'hDEADBEEF to 32'h10010004, load 32'h10010004 -> resp_rdata=32'hDEADBEEF, resp_error=0, resp_valid exactly 3 cycles after each acceptance.
REQ-032 Load 32'h10010006 and load 32'h10010400 (DEPTH_LOG2=8) -> resp_error=1, resp_rdata=0; store to 32'h1000FFFC -> resp_error=1, storage unchanged.
REQ-033 Hold resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; raise resp_ready -> IDLE next cycle, req_ready=1.
REQ-034 Assert reset in WAIT of store 32'h12345678 to 32'h10010000 (previously 32'h0) -> load returns 32'h0.
REQ-035 WAIT_CYCLES=0 build: store then load 32'h100103FC with 32'hA5A5A5A5 -> resp_valid one cycle after each acceptance, data matches.
REQ-036 DMEM_BYTE_MASK_EN build: word 32'h11223344, store 32'hAABBCCDD mask 4'b0101 -> load returns 32'h11BB33DD.
